// File: rtl/hwpe_dma_pkg.sv
// rtl/hwpe_dma_pkg.sv - shared types and constants for the hwpe DMA loader
package hwpe_dma_pkg;

    localparam int HWPE_ADDR_WIDTH = 16;
    localparam int HWPE_LEN_WIDTH  = 16;
    localparam int DMA_WORD_BYTES  = 8;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_LO   = 2'd1,
        DMA_HI   = 2'd2,
        DMA_LAST = 2'd3
    } dma_state_e;

endpackage

// File: rtl/hwpe_dma_loader.sv
// rtl/hwpe_dma_loader.sv - packs a 32-bit source stream into 64-bit SRAM writes
module hwpe_dma_loader
    import hwpe_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = HWPE_ADDR_WIDTH,
    parameter int LEN_WIDTH  = HWPE_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [31:0]           src_data,
    input  logic                  abort,
    output logic                  dma_wen,
    output logic [ADDR_WIDTH-1:0] dma_wa,
    output logic [63:0]           dma_wd,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DMA_WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DMA_WORD_BYTES);

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [31:0]           lo_q, lo_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [63:0]           wd_q, wd_d;
    logic                  done_q, done_d;

    // The done cycle is still IDLE, so it has to be masked out of cmd_ready.
    assign cmd_ready = (state_q == DMA_IDLE) && !done_q;
    assign src_ready = (state_q == DMA_LO) || (state_q == DMA_HI);
    assign busy      = (state_q != DMA_IDLE);
    assign dma_wen   = wen_q;
    assign dma_wa    = wa_q;
    assign dma_wd    = wd_q;
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        lo_d     = lo_q;
        wen_d    = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d = DMA_IDLE;
            lo_d    = '0;
        end else begin
            unique case (state_q)
                DMA_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_len != '0) begin
                            addr_d   = cmd_dst_addr & ALIGN_MASK;
                            remain_d = cmd_len;
                            state_d  = DMA_LO;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                DMA_LO: begin
                    if (src_valid) begin
                        lo_d    = src_data;
                        state_d = DMA_HI;
                    end
                end
                DMA_HI: begin
                    if (src_valid) begin
                        wen_d    = 1'b1;
                        wa_d     = addr_q;
                        wd_d     = {src_data, lo_q};
                        addr_d   = addr_q + ADDR_STEP;
                        remain_d = remain_q - 1'b1;
                        state_d  = (remain_q == LEN_WIDTH'(1)) ? DMA_LAST : DMA_LO;
                    end
                end
                DMA_LAST: begin
                    done_d  = 1'b1;
                    state_d = DMA_IDLE;
                end
                default: state_d = DMA_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DMA_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            lo_q     <= '0;
            wen_q    <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            lo_q     <= lo_d;
            wen_q    <= wen_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            done_q   <= done_d;
        end
    end

endmodule
